// File: rtl/cursor_ctrl.sv
`timescale 1ns/1ps
// cursor_ctrl
//   Moves a square object around the visible area under control of four
//   push-buttons. Each button is synchronised, debounced by its own
//   four-state FSM, and turned into move events (one on press, then one
//   every REPEAT cycles while held). Events step the object's top-left
//   corner by STEP pixels, clamped so the object stays fully on screen.
//
// Ports
//   clk                         system clock, all state on rising edge
//   reset                       asynchronous, active-low reset
//   btn_u, btn_d, btn_l, btn_r  raw bouncy buttons, active-high
//   u, d, l, r                  debounced button levels
//   next_x, next_y              registered object top-left position
//   move                        one-cycle pulse when next_x/next_y changed
module cursor_ctrl #(
  parameter int DB_COUNT = 500000,
  parameter int REPEAT   = 12500000,
  parameter int STEP     = 8,
  parameter int OBJ_SIZE = 16,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 312,
  parameter int Y_INIT   = 232
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic       u,
  output logic       d,
  output logic       l,
  output logic       r,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       move
);

  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  // 11-bit signed working range: wide enough that pos +/- STEP never wraps
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_LIM  = 11'(X_MAX + 1 - OBJ_SIZE);
  localparam logic signed [10:0] Y_LIM  = 11'(Y_MAX + 1 - OBJ_SIZE);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } db_state_t;

  // index 0..3 = up, down, left, right
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] ev;

  assign raw = {btn_r, btn_l, btn_d, btn_u};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic [1:0]    sync_reg;
      db_state_t     state_reg;
      logic [CW-1:0] cnt_reg;
      logic          level_reg;
      logic [RW-1:0] rep_reg;

      // The counter is loaded with 1 on leaving a stable state, so it holds
      // the number of consecutive samples that disagreed with the level.
      // The level flips on the DB_COUNT-th such sample, which makes the
      // press-to-level latency exactly 2 (sync) + DB_COUNT cycles.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg  <= '0;
          state_reg <= S_LOW;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[0], raw[gi]};
          case (state_reg)
            S_LOW: begin
              if (sync_reg[1]) begin
                state_reg <= S_WAIT_HIGH;
                cnt_reg   <= CW'(1);
              end
            end
            S_WAIT_HIGH: begin
              if (!sync_reg[1]) begin
                state_reg <= S_LOW;
                cnt_reg   <= '0;
              end else if (cnt_reg >= CW'(DB_COUNT - 1)) begin
                state_reg <= S_HIGH;
                level_reg <= 1'b1;
                cnt_reg   <= '0;
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
            S_HIGH: begin
              if (!sync_reg[1]) begin
                state_reg <= S_WAIT_LOW;
                cnt_reg   <= CW'(1);
              end
            end
            S_WAIT_LOW: begin
              if (sync_reg[1]) begin
                state_reg <= S_HIGH;
                cnt_reg   <= '0;
              end else if (cnt_reg >= CW'(DB_COUNT - 1)) begin
                state_reg <= S_LOW;
                level_reg <= 1'b0;
                cnt_reg   <= '0;
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
            default: begin
              state_reg <= S_LOW;
              cnt_reg   <= '0;
              level_reg <= 1'b0;
            end
          endcase
        end
      end

      // Repeat phase counter: 0 in the first cycle of a high level (the
      // press event) and again every REPEAT cycles while the level holds.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rep_reg <= '0;
        end else if (!level_reg) begin
          rep_reg <= '0;
        end else if (rep_reg == RW'(REPEAT - 1)) begin
          rep_reg <= '0;
        end else begin
          rep_reg <= rep_reg + RW'(1);
        end
      end

      assign level[gi] = level_reg;
      assign ev[gi]    = level_reg && (rep_reg == '0);
    end
  endgenerate

  assign u = level[0];
  assign d = level[1];
  assign l = level[2];
  assign r = level[3];

  // One axis step: opposing events cancel; the decision is made in the
  // 11-bit signed domain so the 10-bit result is always already in range.
  function automatic logic [9:0] step_axis(input logic [9:0]        pos,
                                           input logic              dec,
                                           input logic              inc,
                                           input logic signed [10:0] lim);
    logic signed [10:0] p;
    logic [9:0]         res;
    p   = signed'({1'b0, pos});
    res = pos;
    if (dec && !inc) begin
      if (p - STEP_S < 11'sd0) res = '0;
      else                     res = pos - 10'(STEP);
    end else if (inc && !dec) begin
      if (p + STEP_S > lim) res = 10'(lim);
      else                  res = pos + 10'(STEP);
    end
    return res;
  endfunction

  logic [9:0] x_reg, y_reg;
  logic [9:0] x_next, y_next;
  logic       move_reg;

  always_comb begin
    x_next = step_axis(x_reg, ev[2], ev[3], X_LIM);
    y_next = step_axis(y_reg, ev[0], ev[1], Y_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg    <= 10'(X_INIT);
      y_reg    <= 10'(Y_INIT);
      move_reg <= 1'b0;
    end else begin
      x_reg    <= x_next;
      y_reg    <= y_next;
      // pulse only on a real change, so pushing against an edge is silent
      move_reg <= (x_next != x_reg) || (y_next != y_reg);
    end
  end

  assign next_x = x_reg;
  assign next_y = y_reg;
  assign move   = move_reg;

endmodule

// File: tb/tb_cursor_ctrl.sv
`timescale 1ns/1ps
// tb_cursor_ctrl
//   Randomised and directed stimulus for cursor_ctrl with a behavioural
//   reference model. The model pushes expected level changes and moves
//   (with the cycle they must appear in) into queues; a monitor pops and
//   compares whenever the DUT shows a level change or a move pulse.
module tb_cursor_ctrl;

  localparam int DB   = 4;
  localparam int RP   = 20;
  localparam int STEP = 8;
  localparam int XI   = 312;
  localparam int YI   = 232;
  localparam int XLIM = 639 + 1 - 16;
  localparam int YLIM = 479 + 1 - 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic       u, d, l, r, move;
  logic [9:0] next_x, next_y;

  cursor_ctrl #(.DB_COUNT(DB), .REPEAT(RP), .STEP(STEP)) dut (
    .clk(clk), .reset(reset),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .u(u), .d(d), .l(l), .r(r),
    .next_x(next_x), .next_y(next_y), .move(move)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int idx; bit val; } lvl_rec_t;
  typedef struct { int cyc; int x; int y; }     mov_rec_t;

  lvl_rec_t lvl_q[$];
  mov_rec_t mov_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int m_x = XI;
  int m_y = YI;

  task automatic check(input string name, input bit ok, input string got, input string req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %s, required %s", name, got, req);
    end
  endtask

  // ---------------- reference model (runs on every rising edge) ----------
  // Spec rules: synced input = raw two edges earlier; the level flips once
  // the synced input has disagreed with it for DB consecutive samples;
  // while high, events occur every RP cycles starting with the first.
  initial begin : model
    int  mc;
    bit  s1[4], s2[4], lvl[4], raw[4], ev[4];
    int  run[4], hold[4];
    int  nx, ny;
    mc = 0;
    for (int i = 0; i < 4; i++) begin
      s1[i] = 0; s2[i] = 0; lvl[i] = 0; run[i] = 0; hold[i] = 0;
    end
    forever begin
      @(posedge clk);
      mc++;
      raw[0] = btn_u; raw[1] = btn_d; raw[2] = btn_l; raw[3] = btn_r;
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin
          s1[i] = 0; s2[i] = 0; lvl[i] = 0; run[i] = 0; hold[i] = 0;
        end
        m_x = XI;
        m_y = YI;
        lvl_q.delete();
        mov_q.delete();
      end else begin
        for (int i = 0; i < 4; i++) ev[i] = lvl[i] && (hold[i] % RP == 0);
        nx = m_x;
        ny = m_y;
        if (ev[0] && !ev[1]) ny = (m_y - STEP < 0) ? 0 : m_y - STEP;
        if (ev[1] && !ev[0]) ny = (m_y + STEP > YLIM) ? YLIM : m_y + STEP;
        if (ev[2] && !ev[3]) nx = (m_x - STEP < 0) ? 0 : m_x - STEP;
        if (ev[3] && !ev[2]) nx = (m_x + STEP > XLIM) ? XLIM : m_x + STEP;
        if (nx != m_x || ny != m_y) mov_q.push_back('{mc, nx, ny});
        m_x = nx;
        m_y = ny;
        for (int i = 0; i < 4; i++) begin
          if (s2[i] != lvl[i]) run[i]++;
          else                 run[i] = 0;
          if (run[i] == DB) begin
            lvl[i]  = s2[i];
            run[i]  = 0;
            hold[i] = 0;
            lvl_q.push_back('{mc, i, lvl[i]});
          end else if (lvl[i]) begin
            hold[i]++;
          end
          s2[i] = s1[i];
          s1[i] = raw[i];
        end
      end
    end
  end

  // ---------------- monitor / scoreboard (falling edge) -------------------
  initial begin : monitor
    int         mcyc;
    logic [3:0] prev_lvl, cur;
    lvl_rec_t   le;
    mov_rec_t   me;
    mcyc     = 0;
    prev_lvl = 4'b0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (!reset) begin
        prev_lvl = 4'b0;
      end else begin
        cur = {r, l, d, u};
        for (int i = 0; i < 4; i++) begin
          if (cur[i] !== prev_lvl[i]) begin
            check("level_expected", lvl_q.size() > 0,
                  $sformatf("btn%0d -> %b at cyc %0d", i, cur[i], mcyc), "a queued level change");
            if (lvl_q.size() > 0) begin
              le = lvl_q.pop_front();
              check("level_change", le.cyc == mcyc && le.idx == i && le.val == cur[i],
                    $sformatf("cyc %0d btn%0d=%b", mcyc, i, cur[i]),
                    $sformatf("cyc %0d btn%0d=%b", le.cyc, le.idx, le.val));
              $display("[cyc %0d] level btn%0d = %b", mcyc, i, cur[i]);
            end
          end
        end
        prev_lvl = cur;
        if (move === 1'b1) begin
          check("move_expected", mov_q.size() > 0,
                $sformatf("move at cyc %0d x=%0d y=%0d", mcyc, next_x, next_y), "a queued move");
          if (mov_q.size() > 0) begin
            me = mov_q.pop_front();
            check("move_pos", me.cyc == mcyc && me.x == int'(next_x) && me.y == int'(next_y),
                  $sformatf("cyc %0d x=%0d y=%0d", mcyc, next_x, next_y),
                  $sformatf("cyc %0d x=%0d y=%0d", me.cyc, me.x, me.y));
            $display("[cyc %0d] move x=%0d y=%0d", mcyc, next_x, next_y);
          end
        end
        if (mov_q.size() > 0) begin
          check("move_timely", mov_q[0].cyc > mcyc,
                $sformatf("no move by cyc %0d", mcyc), $sformatf("move at cyc %0d", mov_q[0].cyc));
          if (mov_q[0].cyc <= mcyc) void'(mov_q.pop_front());
        end
        if (lvl_q.size() > 0) begin
          check("level_timely", lvl_q[0].cyc > mcyc,
                $sformatf("no change by cyc %0d", mcyc), $sformatf("change at cyc %0d", lvl_q[0].cyc));
          if (lvl_q[0].cyc <= mcyc) void'(lvl_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);  // {r, l, d, u}
    {btn_r, btn_l, btn_d, btn_u} = b;
  endtask

  task automatic check_reset_state(input string name);
    check(name, next_x == 10'(XI) && next_y == 10'(YI) && {u, d, l, r} == 4'b0 && move == 1'b0,
          $sformatf("x=%0d y=%0d udlr=%b move=%b", next_x, next_y, {u, d, l, r}, move),
          $sformatf("x=%0d y=%0d udlr=0000 move=0", XI, YI));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    check_reset_state("reset_async");
    repeat (n) tick();
    check_reset_state("reset_held");
    reset = 1'b1;
  endtask

  task automatic hold_and_count(input logic [3:0] b, input int n, output int moves);
    set_btn(b);
    moves = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (move) moves++;
    end
  endtask

  initial begin : stim
    int n, moves, bad;
    set_btn(4'b0);
    repeat (3) tick();
    check_reset_state("reset_initial");
    reset = 1'b1;

    // idle after reset
    hold_and_count(4'b0000, 30, moves);
    check("idle", moves == 0 && next_x == 10'(XI) && next_y == 10'(YI) && {u, d, l, r} == 4'b0,
          $sformatf("moves=%0d x=%0d y=%0d", moves, next_x, next_y), "moves=0 x=312 y=232");

    // clean right press: latency, first step, repeat step
    set_btn(4'b1000);
    n = 0;
    while (!r && n < 50) begin tick(); n++; end
    check("r_latency", n == 2 + DB, $sformatf("%0d cycles", n), $sformatf("%0d cycles", 2 + DB));
    tick();
    check("r_first_step", next_x == 10'(XI + STEP) && move == 1'b1,
          $sformatf("x=%0d move=%b", next_x, move), $sformatf("x=%0d move=1", XI + STEP));
    repeat (RP) tick();
    check("r_repeat_step", next_x == 10'(XI + 2 * STEP) && move == 1'b1,
          $sformatf("x=%0d move=%b", next_x, move), $sformatf("x=%0d move=1", XI + 2 * STEP));
    set_btn(4'b0);
    repeat (10) tick();
    do_reset(2);

    // bounce on up shorter than the debounce window
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      btn_u = ((k / 2) % 2 == 0);
      tick();
      if (u || move) bad++;
    end
    btn_u = 1'b0;
    repeat (10) begin tick(); if (u || move) bad++; end
    check("bounce", bad == 0 && next_y == 10'(YI),
          $sformatf("bad_cycles=%0d y=%0d", bad, next_y), "bad_cycles=0 y=232");

    // left+right cancel while down moves
    set_btn(4'b1110);
    repeat (2 + DB + 1) tick();
    check("lr_cancel_down", next_x == 10'(XI) && next_y == 10'(YI + STEP) && move == 1'b1,
          $sformatf("x=%0d y=%0d move=%b", next_x, next_y, move),
          $sformatf("x=%0d y=%0d move=1", XI, YI + STEP));
    repeat (30) tick();
    check("lr_hold", next_x == 10'(XI), $sformatf("x=%0d", next_x), $sformatf("x=%0d", XI));
    set_btn(4'b0);
    repeat (10) tick();
    do_reset(2);

    // top boundary: 232/8 = 29 real moves, then silent at 0
    hold_and_count(4'b0001, 700, moves);
    check("up_clamp", next_y == 10'd0 && moves == 29,
          $sformatf("y=%0d moves=%0d", next_y, moves), "y=0 moves=29");
    set_btn(4'b0);
    repeat (10) tick();
    do_reset(2);

    // bottom boundary: (464-232)/8 = 29 real moves, then silent at 464
    hold_and_count(4'b0010, 700, moves);
    check("down_clamp", next_y == 10'(YLIM) && moves == 29,
          $sformatf("y=%0d moves=%0d", next_y, moves), $sformatf("y=%0d moves=29", YLIM));
    set_btn(4'b0);
    repeat (10) tick();
    do_reset(2);

    // reset in the middle of a debounce, button still held
    set_btn(4'b1000);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("rst_mid_debounce", next_x == 10'(XI) && move == 1'b0 && r == 1'b0,
          $sformatf("x=%0d move=%b r=%b", next_x, move, r), "x=312 move=0 r=0");
    tick();
    reset = 1'b1;
    n = 0;
    while (next_x == 10'(XI) && n < 50) begin tick(); n++; end
    check("rst_restart_latency", n == 3 + DB && next_x == 10'(XI + STEP) && move == 1'b1,
          $sformatf("%0d cycles x=%0d move=%b", n, next_x, move),
          $sformatf("%0d cycles x=%0d move=1", 3 + DB, XI + STEP));
    set_btn(4'b0);
    repeat (10) tick();
    do_reset(2);

    // randomised segments: stable holds, bounces, occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      int mode;
      mode = int'($urandom_range(0, 19));
      if (mode == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (mode < 6) begin
        repeat ($urandom_range(4, 30)) begin
          set_btn(4'($urandom));
          tick();
        end
      end else begin
        set_btn(4'($urandom));
        repeat ($urandom_range(5, 120)) tick();
      end
    end

    set_btn(4'b0);
    reset = 1'b1;
    repeat (40) tick();
    check("lvl_q_drained", lvl_q.size() == 0, $sformatf("%0d pending", lvl_q.size()), "0 pending");
    check("mov_q_drained", mov_q.size() == 0, $sformatf("%0d pending", mov_q.size()), "0 pending");
    check("final_pos", int'(next_x) == m_x && int'(next_y) == m_y,
          $sformatf("x=%0d y=%0d", next_x, next_y), $sformatf("x=%0d y=%0d", m_x, m_y));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameter DB_COUNT, default 500000, SHALL set debounce stability window in clk cycles (10 ms at 50 MHz).
REQ-002 Parameter REPEAT, default 12500000, SHALL set auto-repeat period in clk cycles while a direction is held.
REQ-003 Parameter STEP, default 8, SHALL set pixels moved per move event.
REQ-004 Parameter OBJ_SIZE, default 16, SHALL set object width/height in pixels.
REQ-005 Parameters X_MAX/Y_MAX, defaults 639/479, SHALL set last visible pixel column/row.
REQ-006 Parameters X_INIT/Y_INIT, defaults 312/232, SHALL set reset position of the object's top-left corner.
REQ-007 clk  in  1  single system clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-009 btn_u, btn_d, btn_l, btn_r  in  1 each  raw, asynchronous, bouncy push-buttons, active-high.
REQ-010 u, d, l, r  out  1 each  debounced button levels, fed to the graphics stage.
REQ-011 next_x, next_y  out  10 each  registered object top-left position, fed to the display stage.
REQ-012 move  out  1  one-cycle pulse, high the cycle next_x/next_y take a new value.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each button SHALL have an independent debounce FSM with states LOW, WAIT_HIGH, HIGH, WAIT_LOW and its own counter.
REQ-015 LOW->WAIT_HIGH on synced 1; WAIT_HIGH->HIGH when counter reaches DB_COUNT-1 with input still 1; WAIT_HIGH->LOW (counter cleared) on any synced 0.
REQ-016 HIGH->WAIT_LOW on synced 0; WAIT_LOW->LOW when counter reaches DB_COUNT-1 with input still 0; WAIT_LOW->HIGH (counter cleared) on any synced 1.
REQ-017 Debounced level SHALL be 1 in HIGH and WAIT_LOW, 0 otherwise; u/d/l/r are registered copies of these levels.
REQ-018 A move event for a direction SHALL fire on the debounced level's rising edge and then every REPEAT cycles while it stays 1; the repeat counter SHALL clear when the level falls.
REQ-019 Up event: next_y -= STEP, clamped to 0; down event: next_y += STEP, clamped to Y_MAX+1-OBJ_SIZE; left/right likewise on next_x with X_MAX.
REQ-020 Clamp arithmetic SHALL use 11-bit signed-safe intermediates; no 10-bit wrap-around ever appears on next_x/next_y.
REQ-021 Up and down events in the same cycle SHALL cancel (next_y unchanged); left and right likewise; the x and y axes update independently in the same cycle.
REQ-022 Position SHALL update on the clock edge after the move event; move SHALL pulse in that same cycle only if next_x or next_y actually changed (no pulse when held against a boundary).
REQ-023 Latency from a clean raw press to the debounced level rising SHALL be 2 + DB_COUNT cycles; the position changes 1 cycle after that.
REQ-024 A bounce shorter than DB_COUNT cycles SHALL produce no level change, no move event and no move pulse.

Reset
REQ-025 While reset = 0, all FSMs SHALL be LOW, all counters and synchronizers 0, u/d/l/r = 0, move = 0, next_x = X_INIT, next_y = Y_INIT, immediately and independently of clk.
REQ-026 Reset asserted mid-debounce or mid-repeat SHALL discard the pending event; after release, a still-held button SHALL require a full 2 + DB_COUNT cycles before its first event.

Verification (DB_COUNT=4, REPEAT=20, STEP=8, defaults otherwise)
REQ-027 Reset release, no buttons -> next_x=312, next_y=232, u/d/l/r=0, move=0 indefinitely.
REQ-028 btn_r held 1 -> r rises 6 cycles after press; next_x=320 with move=1 on the following cycle; next_x=328 twenty cycles later.
REQ-029 btn_u toggled 1/0 every 2 cycles for 40 cycles -> u stays 0, next_y stays 232, move never pulses.
REQ-030 btn_l and btn_r pressed in the same cycle and held -> next_x stays 312, move stays 0; btn_d pressed simultaneously -> next_y=240 with move=1.
REQ-031 btn_u held from next_y=8 -> next_y=0 then stays 0, move pulses once only; btn_d held from next_y=460 -> next_y=464 then stays 464.
REQ-032 reset pulsed low while btn_r is held in WAIT_HIGH -> next_x=312 with no move pulse; after release the first increment occurs 7 cycles after reset deasserts.
